i2c_xact_ctrl: RTL and testbench
================================

Name: i2c_xact_ctrl

Overview:
- CLK40-domain transaction controller that sits directly upstream of the I2C master interface.
- Accepts host payload bytes and a "go" command. Programs the interface's byte memory, byte-count/direction register and register address, then drives EXECUTE.
- Tracks READY across the CLK1MHZ boundary and collects readback bytes into a 16-deep FIFO.
- Reports done, slave NACK and timeout status to the host.

Parameters:
- TIMEOUT_CYC, 80000, CLK40 cycles allowed in each of EXEC and WAIT before abort (2 ms).
- RBK_AW, 4, readback FIFO address width; depth = 2**RBK_AW.

Ports:
- CLK40 in 1 system clock.
- RST in 1 asynchronous, active-high reset.
- HOST_WE in 1 push payload byte (IDLE only).
- HOST_DATA in 8 payload byte.
- HOST_GO in 1 start transaction, single-cycle pulse.
- GO_NBYTES in 4 byte count; 0 encodes 16.
- GO_READ in 1 1=I2C read, 0=write.
- GO_ADDR in 8 slave register address.
- RBK_RD in 1 pop readback FIFO.
- DEV_SEL out 1 interface select.
- LOAD_N_BYTE out 1 load count/direction.
- LOAD_ADDR out 1 load address.
- WRT_ADDR out 4 interface byte-memory address.
- WRT_DATA out 8 interface write data.
- WRT_ENA out 1 interface byte-memory write.
- EXECUTE out 1 start interface FSM.
- I_READY in 1 interface READY (CLK1MHZ domain).
- I_RBK_WE in 1 readback strobe (one CLK40 cycle).
- I_RBK_DATA in 8 readback byte.
- I_S_NACK in 1 slave NACK flag (CLK1MHZ domain).
- BUSY out 1 transaction in progress.
- DONE out 1 one-cycle completion pulse.
- NACK_ERR out 1 NACK seen in last transaction.
- TO_ERR out 1 last transaction timed out.
- RBK_DOUT out 8 FIFO head, first-word-fall-through.
- RBK_EMPTY out 1 FIFO empty.
- RBK_CNT out RBK_AW+1 FIFO occupancy.
- RBK_OVF out 1 sticky overflow.

Behaviour:
- Reset:
  - All outputs are registered and 0, except RBK_EMPTY=1.
  - wr_ptr=0, state=IDLE, FIFO emptied.
  - ready_s sync chain preset to 1.
- CDC: I_READY and I_S_NACK each pass through 2-flop synchronizers (ready_s, nack_s).
- IDLE, HOST_WE=1:
  - Next cycle: DEV_SEL=1, WRT_ENA=1, WRT_ADDR=wr_ptr, WRT_DATA=HOST_DATA.
  - wr_ptr increments and wraps 15->0.
- HOST_WE outside IDLE is ignored.
- HOST_GO in IDLE: latch nbytes/read/addr, BUSY=1, clear NACK_ERR and TO_ERR, go to SET_N.
  - HOST_WE and HOST_GO in the same IDLE cycle: the byte is written first, then SET_N follows.
  - HOST_GO while BUSY is ignored.
- SET_N, 1 cycle: DEV_SEL=1, LOAD_N_BYTE=1, WRT_DATA={nbytes,read,3'b000}. Go to SET_A.
- SET_A, 1 cycle: DEV_SEL=1, LOAD_ADDR=1, WRT_DATA=addr. Go to EXEC.
- EXEC:
  - DEV_SEL=1 and EXECUTE=1, held until ready_s=0, then go to WAIT.
  - The hold guarantees the 1 MHz FSM samples EXECUTE.
- WAIT: EXECUTE=0, DEV_SEL=1, until ready_s=1, then go to FIN.
- FIN, 1 cycle: DONE=1, NACK_ERR<=nack_s, BUSY<=0, wr_ptr<=0, return to IDLE.
- Timeout: tmo counter clears on entry to EXEC and WAIT.
  - On reaching TIMEOUT_CYC-1: TO_ERR=1, DONE pulse, drop EXECUTE/DEV_SEL, wr_ptr=0, go to IDLE.
- Readback FIFO:
  - Write on I_RBK_WE when not full.
  - I_RBK_WE when full: byte dropped, RBK_OVF=1; cleared only by HOST_GO or RST.
  - RBK_RD when empty is ignored.
  - Simultaneous write and read when full: read pops, write is accepted, count unchanged.
  - Pointers wrap modulo depth.
- Reset mid-transaction: everything returns to reset values immediately; EXECUTE deasserts asynchronously.
- Writes are the host's responsibility: the payload count is not checked against GO_NBYTES.

Optional Feature:
- I2C_XACT_RETRY_EN.
- Defined: on FIN with nack_s=1 and retry count < 2, reload via SET_N and retry; RETRY_CNT out[1:0] reports retries used. DONE/NACK_ERR reflect the final attempt only.
- Undefined: no retry, RETRY_CNT absent.

Decomposition:
- i2c_ctrl_pkg:
  - state encoding IDLE/SET_N/SET_A/EXEC/WAIT/FIN;
  - field positions for the count/direction byte (count [7:4], read [3]);
  - TIMEOUT_CYC default.
- Sub-module i2c_rbk_fifo: the readback FIFO, parameterised by RBK_AW.

Test Plan:
- Write 3 bytes 0x11,0x22,0x33, GO nbytes=3 read=0 addr=0x40:
  - WRT_ADDR 0,1,2;
  - LOAD_N_BYTE with WRT_DATA=0x30, then LOAD_ADDR with 0x40;
  - EXECUTE held until model READY drops;
  - single DONE, NACK_ERR=0.
- GO read nbytes=2, model emits I_RBK_WE with 0xA5,0x5A -> RBK_CNT=2; pops return 0xA5 then 0x5A; RBK_EMPTY=1.
- Model sets S_NACK=1 -> DONE with NACK_ERR=1; next GO clears it.
- Model never drops READY -> TO_ERR=1 after TIMEOUT_CYC cycles, EXECUTE=0, BUSY=0.
- 17 I_RBK_WE without reads -> RBK_CNT=16, RBK_OVF=1, first 16 bytes intact.
- RST asserted in WAIT -> all outputs at reset values in the same cycle; a following GO completes normally.

Source files
------------

// File: rtl/i2c_ctrl_pkg.sv
// i2c_ctrl_pkg: shared types and constants for the I2C transaction controller.
// Holds the FSM state encoding, count/direction byte layout and timeout default.
package i2c_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_N,
        ST_SET_A,
        ST_EXEC,
        ST_WAIT,
        ST_FIN
    } state_t;

    // count/direction byte: count in [7:4], read flag in [3], [2:0] zero
    localparam int NB_MSB = 7;
    localparam int NB_LSB = 4;
    localparam int RD_BIT = 3;

    // 2 ms at 40 MHz
    localparam int TIMEOUT_CYC_DEF = 80000;

    function automatic logic [7:0] nbyte_word(input logic [3:0] n,
                                              input logic       rd);
        logic [7:0] w;
        w = '0;
        w[NB_MSB:NB_LSB] = n;
        w[RD_BIT] = rd;
        return w;
    endfunction

endpackage

// File: rtl/i2c_xact_ctrl_if.sv
// i2c_xact_ctrl_if: bus between the transaction controller (master) and the
// I2C master interface (slave): select/load/write strobes, EXECUTE, READY,
// readback strobe/data and slave NACK flag.
interface i2c_xact_ctrl_if;

    logic       DEV_SEL;
    logic       LOAD_N_BYTE;
    logic       LOAD_ADDR;
    logic [3:0] WRT_ADDR;
    logic [7:0] WRT_DATA;
    logic       WRT_ENA;
    logic       EXECUTE;
    logic       I_READY;
    logic       I_RBK_WE;
    logic [7:0] I_RBK_DATA;
    logic       I_S_NACK;

    modport master (
        output DEV_SEL, LOAD_N_BYTE, LOAD_ADDR,
        output WRT_ADDR, WRT_DATA, WRT_ENA, EXECUTE,
        input  I_READY, I_RBK_WE, I_RBK_DATA, I_S_NACK
    );

    modport slave (
        input  DEV_SEL, LOAD_N_BYTE, LOAD_ADDR,
        input  WRT_ADDR, WRT_DATA, WRT_ENA, EXECUTE,
        output I_READY, I_RBK_WE, I_RBK_DATA, I_S_NACK
    );

endinterface

// File: rtl/i2c_rbk_fifo.sv
// i2c_rbk_fifo: first-word-fall-through readback FIFO, depth 2**AW.
// Ports: CLK40/RST, wr/wdata push, rd pop, ovf_clr, dout head, empty, cnt, sticky ovf.
module i2c_rbk_fifo #(
    parameter int AW = 4
) (
    input  logic          CLK40,
    input  logic          RST,
    input  logic          wr,
    input  logic [7:0]    wdata,
    input  logic          rd,
    input  logic          ovf_clr,
    output logic [7:0]    dout,
    output logic          empty,
    output logic [AW:0]   cnt,
    output logic          ovf
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          full;
    logic          do_rd;
    logic          do_wr;

    assign full  = cnt[AW];
    assign empty = (cnt == '0);
    assign dout  = mem[rp];

    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (do_rd) begin
                rp <= rp + 1'b1;
            end
            if (do_wr && !do_rd) begin
                cnt <= cnt + 1'b1;
            end else if (do_rd && !do_wr) begin
                cnt <= cnt - 1'b1;
            end
            if (ovf_clr) begin
                ovf <= 1'b0;
            end else if (wr && !do_wr) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_xact_ctrl.sv
// i2c_xact_ctrl: CLK40 transaction controller driving the I2C master interface.
// Ports: host payload/GO inputs, bus (master modport), status BUSY/DONE/NACK_ERR/
// TO_ERR, readback FIFO RBK_*. Optional I2C_XACT_RETRY_EN adds NACK retry + RETRY_CNT.
module i2c_xact_ctrl
    import i2c_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int RBK_AW      = 4
) (
    input  logic              CLK40,
    input  logic              RST,
    input  logic              HOST_WE,
    input  logic [7:0]        HOST_DATA,
    input  logic              HOST_GO,
    input  logic [3:0]        GO_NBYTES,
    input  logic              GO_READ,
    input  logic [7:0]        GO_ADDR,
    input  logic              RBK_RD,
    i2c_xact_ctrl_if.master   bus,
    output logic              BUSY,
    output logic              DONE,
    output logic              NACK_ERR,
    output logic              TO_ERR,
    output logic [7:0]        RBK_DOUT,
    output logic              RBK_EMPTY,
    output logic [RBK_AW:0]   RBK_CNT,
    output logic              RBK_OVF
`ifdef I2C_XACT_RETRY_EN
    ,
    output logic [1:0]        RETRY_CNT
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t       state;
    logic [3:0]   wr_ptr;
    logic [3:0]   nbytes_q;
    logic         read_q;
    logic [7:0]   addr_q;
    logic [TMO_W-1:0] tmo;
    logic         tmo_hit;
    logic [1:0]   ready_q;
    logic [1:0]   nack_q;
    logic         ready_s;
    logic         nack_s;
    logic         go_ok;

    // READY idles high, so the chain starts high to avoid a false busy
    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            ready_q <= 2'b11;
            nack_q  <= 2'b00;
        end else begin
            ready_q <= {ready_q[0], bus.I_READY};
            nack_q  <= {nack_q[0], bus.I_S_NACK};
        end
    end

    assign ready_s = ready_q[1];
    assign nack_s  = nack_q[1];
    assign tmo_hit = (tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign go_ok   = HOST_GO && (state == ST_IDLE);

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            state           <= ST_IDLE;
            wr_ptr          <= '0;
            nbytes_q        <= '0;
            read_q          <= 1'b0;
            addr_q          <= '0;
            tmo             <= '0;
            bus.DEV_SEL     <= 1'b0;
            bus.LOAD_N_BYTE <= 1'b0;
            bus.LOAD_ADDR   <= 1'b0;
            bus.WRT_ADDR    <= '0;
            bus.WRT_DATA    <= '0;
            bus.WRT_ENA     <= 1'b0;
            bus.EXECUTE     <= 1'b0;
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            NACK_ERR        <= 1'b0;
            TO_ERR          <= 1'b0;
`ifdef I2C_XACT_RETRY_EN
            RETRY_CNT       <= 2'd0;
`endif
        end else begin
            DONE            <= 1'b0;
            bus.WRT_ENA     <= 1'b0;
            bus.LOAD_N_BYTE <= 1'b0;
            bus.LOAD_ADDR   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    bus.DEV_SEL <= HOST_WE;
                    if (HOST_WE) begin
                        bus.WRT_ENA  <= 1'b1;
                        bus.WRT_ADDR <= wr_ptr;
                        bus.WRT_DATA <= HOST_DATA;
                        wr_ptr       <= wr_ptr + 1'b1;
                    end
                    // a same-cycle byte is emitted first; SET_N output follows
                    if (HOST_GO) begin
                        nbytes_q <= GO_NBYTES;
                        read_q   <= GO_READ;
                        addr_q   <= GO_ADDR;
                        BUSY     <= 1'b1;
                        NACK_ERR <= 1'b0;
                        TO_ERR   <= 1'b0;
`ifdef I2C_XACT_RETRY_EN
                        RETRY_CNT <= 2'd0;
`endif
                        state    <= ST_SET_N;
                    end
                end
                ST_SET_N: begin
                    bus.DEV_SEL     <= 1'b1;
                    bus.LOAD_N_BYTE <= 1'b1;
                    bus.WRT_DATA    <= nbyte_word(nbytes_q, read_q);
                    state           <= ST_SET_A;
                end
                ST_SET_A: begin
                    bus.DEV_SEL   <= 1'b1;
                    bus.LOAD_ADDR <= 1'b1;
                    bus.WRT_DATA  <= addr_q;
                    tmo           <= '0;
                    state         <= ST_EXEC;
                end
                ST_EXEC, ST_WAIT: begin
                    if (tmo_hit) begin
                        bus.EXECUTE <= 1'b0;
                        bus.DEV_SEL <= 1'b0;
                        TO_ERR      <= 1'b1;
                        DONE        <= 1'b1;
                        BUSY        <= 1'b0;
                        wr_ptr      <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo         <= tmo + 1'b1;
                        bus.DEV_SEL <= 1'b1;
                        if (state == ST_EXEC) begin
                            // hold EXECUTE until the slow FSM shows it saw it
                            if (!ready_s) begin
                                bus.EXECUTE <= 1'b0;
                                tmo         <= '0;
                                state       <= ST_WAIT;
                            end else begin
                                bus.EXECUTE <= 1'b1;
                            end
                        end else if (ready_s) begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
`ifdef I2C_XACT_RETRY_EN
                    if (nack_s && (RETRY_CNT < 2'd2)) begin
                        RETRY_CNT <= RETRY_CNT + 1'b1;
                        state     <= ST_SET_N;
                    end else
`endif
                    begin
                        DONE        <= 1'b1;
                        NACK_ERR    <= nack_s;
                        BUSY        <= 1'b0;
                        bus.DEV_SEL <= 1'b0;
                        wr_ptr      <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    i2c_rbk_fifo #(
        .AW (RBK_AW)
    ) u_fifo (
        .CLK40   (CLK40),
        .RST     (RST),
        .wr      (bus.I_RBK_WE),
        .wdata   (bus.I_RBK_DATA),
        .rd      (RBK_RD),
        .ovf_clr (go_ok),
        .dout    (RBK_DOUT),
        .empty   (RBK_EMPTY),
        .cnt     (RBK_CNT),
        .ovf     (RBK_OVF)
    );

endmodule

// File: tb/tb_i2c_xact_ctrl.sv
// tb_i2c_xact_ctrl: directed bench for i2c_xact_ctrl with a behavioural
// I2C-interface model driving READY, readback strobes and NACK.
module tb_i2c_xact_ctrl;

    localparam int T = 64;

    logic       CLK40 = 1'b0;
    logic       RST;
    logic       HOST_WE, HOST_GO, GO_READ, RBK_RD;
    logic [7:0] HOST_DATA, GO_ADDR;
    logic [3:0] GO_NBYTES;
    logic       BUSY, DONE, NACK_ERR, TO_ERR, RBK_EMPTY, RBK_OVF;
    logic [7:0] RBK_DOUT;
    logic [4:0] RBK_CNT;

    i2c_xact_ctrl_if bus();

    i2c_xact_ctrl #(.TIMEOUT_CYC(T), .RBK_AW(4)) dut (
        .CLK40(CLK40), .RST(RST),
        .HOST_WE(HOST_WE), .HOST_DATA(HOST_DATA), .HOST_GO(HOST_GO),
        .GO_NBYTES(GO_NBYTES), .GO_READ(GO_READ), .GO_ADDR(GO_ADDR),
        .RBK_RD(RBK_RD), .bus(bus),
        .BUSY(BUSY), .DONE(DONE), .NACK_ERR(NACK_ERR), .TO_ERR(TO_ERR),
        .RBK_DOUT(RBK_DOUT), .RBK_EMPTY(RBK_EMPTY), .RBK_CNT(RBK_CNT),
        .RBK_OVF(RBK_OVF)
    );

    always #5 CLK40 = ~CLK40;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // monitor
    logic [11:0] wq[$];
    int   cyc = 0, done_cnt = 0, ln_t = 0, la_t = 0;
    logic [7:0] ln_d, la_d;

    always @(negedge CLK40) begin
        cyc++;
        if (bus.WRT_ENA) wq.push_back({bus.WRT_ADDR, bus.WRT_DATA});
        if (bus.LOAD_N_BYTE) begin ln_d = bus.WRT_DATA; ln_t = cyc; end
        if (bus.LOAD_ADDR) begin la_d = bus.WRT_DATA; la_t = cyc; end
        if (DONE) done_cnt++;
    end

    // I2C interface model
    bit         model_hang = 0, model_nack = 0;
    int         model_nrbk = 0;
    logic [7:0] model_rbk [2] = '{8'hA5, 8'h5A};
    logic       exec_at_drop = 1'b0;

    initial begin
        bus.I_READY = 1'b1; bus.I_RBK_WE = 1'b0;
        bus.I_RBK_DATA = 8'h00; bus.I_S_NACK = 1'b0;
        forever begin
            @(negedge CLK40);
            if (bus.EXECUTE && bus.I_READY && !model_hang && !RST) begin
                bus.I_S_NACK = 1'b0;
                repeat (2) @(negedge CLK40);
                exec_at_drop = bus.EXECUTE;
                bus.I_READY = 1'b0;
                repeat (4) @(negedge CLK40);
                for (int i = 0; i < model_nrbk; i++) begin
                    bus.I_RBK_DATA = model_rbk[i]; bus.I_RBK_WE = 1'b1;
                    @(negedge CLK40);
                    bus.I_RBK_WE = 1'b0;
                    @(negedge CLK40);
                end
                bus.I_S_NACK = model_nack;
                repeat (4) @(negedge CLK40);
                bus.I_READY = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    function automatic logic [10:0] flags();
        return {bus.DEV_SEL, bus.LOAD_N_BYTE, bus.LOAD_ADDR, bus.WRT_ENA,
                bus.EXECUTE, BUSY, DONE, NACK_ERR, TO_ERR, RBK_EMPTY, RBK_OVF};
    endfunction

    task automatic push(input logic [7:0] d);
        HOST_WE = 1'b1; HOST_DATA = d;
        @(negedge CLK40);
        HOST_WE = 1'b0;
    endtask

    task automatic go(input logic [3:0] n, input logic rd, input logic [7:0] a);
        GO_NBYTES = n; GO_READ = rd; GO_ADDR = a; HOST_GO = 1'b1;
        @(negedge CLK40);
        HOST_GO = 1'b0;
    endtask

    task automatic pop();
        RBK_RD = 1'b1;
        @(negedge CLK40);
        RBK_RD = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK40);
            if (DONE) begin seen = 1; break; end
        end
        check("done_seen", 32'(seen), 1);
    endtask

    task automatic wait_sig(input string tag, input bit lvl, input bit is_exec);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            if ((is_exec ? bus.EXECUTE : bus.I_READY) == lvl) begin
                seen = 1; break;
            end
            @(negedge CLK40);
        end
        check(tag, 32'(seen), 1);
    endtask

    initial begin
        int d0, lat;
        RST = 1'b1; HOST_WE = 0; HOST_GO = 0; RBK_RD = 0;
        HOST_DATA = 0; GO_NBYTES = 0; GO_READ = 0; GO_ADDR = 0;
        repeat (3) @(negedge CLK40);
        check("rst_flags", 32'(flags()), 32'b000_0000_0010);
        check("rst_bus", {bus.WRT_ADDR, bus.WRT_DATA, RBK_DOUT, RBK_CNT}, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK40);

        // write transaction
        wq.delete();
        push(8'h11); push(8'h22); push(8'h33);
        d0 = done_cnt;
        go(4'd3, 1'b0, 8'h40);
        wait_done(300);
        check("w_nack", 32'(NACK_ERR), 0);
        check("w_to", 32'(TO_ERR), 0);
        check("w_busy", 32'(BUSY), 0);
        repeat (10) @(negedge CLK40);
        check("w_nwr", wq.size(), 3);
        check("w_wr0", 32'(wq[0]), 12'h011);
        check("w_wr1", 32'(wq[1]), 12'h122);
        check("w_wr2", 32'(wq[2]), 12'h233);
        check("w_ldn", 32'(ln_d), 8'h30);
        check("w_lda", 32'(la_d), 8'h40);
        check("w_ldord", 32'(la_t - ln_t), 1);
        check("w_exhold", 32'(exec_at_drop), 1);
        check("w_1done", 32'(done_cnt - d0), 1);

        // read transaction with two readback bytes
        model_nrbk = 2;
        go(4'd2, 1'b1, 8'h07);
        wait_done(300);
        model_nrbk = 0;
        check("r_ldn", 32'(ln_d), 8'h28);
        check("r_cnt", 32'(RBK_CNT), 2);
        check("r_d0", 32'(RBK_DOUT), 8'hA5);
        pop();
        check("r_d1", 32'(RBK_DOUT), 8'h5A);
        pop();
        check("r_empty", {RBK_EMPTY, RBK_CNT}, {1'b1, 5'd0});

        // NACK, then the next GO clears it; HOST_WE while busy is ignored
        model_nack = 1;
        go(4'd1, 1'b0, 8'h10);
        wait_done(300);
        check("n_err", 32'(NACK_ERR), 1);
        model_nack = 0;
        wq.delete();
        go(4'd1, 1'b0, 8'h10);
        check("n_clr", 32'(NACK_ERR), 0);
        push(8'hEE);
        wait_done(300);
        check("n_err2", 32'(NACK_ERR), 0);
        check("n_bwe", wq.size(), 0);

        // timeout: READY never drops
        model_hang = 1;
        go(4'd1, 1'b0, 8'h20);
        wait_sig("t_exec", 1'b1, 1'b1);
        lat = 0;
        for (int i = 1; i < T + 20; i++) begin
            @(negedge CLK40);
            if (DONE) begin lat = i; break; end
        end
        check("t_lat", lat, T - 1);
        check("t_flags", 32'(flags()), 32'b000_0001_0110);
        model_hang = 0;
        repeat (3) @(negedge CLK40);

        // overflow: 17 strobes without reads
        for (int i = 0; i < 17; i++) begin
            bus.I_RBK_DATA = 8'(8'h80 + i); bus.I_RBK_WE = 1'b1;
            @(negedge CLK40);
        end
        bus.I_RBK_WE = 1'b0;
        check("o_cnt", 32'(RBK_CNT), 16);
        check("o_ovf", 32'(RBK_OVF), 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("o_d%0d", i), 32'(RBK_DOUT), 32'(8'h80 + i));
            pop();
        end
        check("o_empty", {RBK_EMPTY, RBK_OVF}, 2'b11);

        // reset in WAIT, then a clean transaction
        go(4'd1, 1'b0, 8'h30);
        check("x_ovfclr", 32'(RBK_OVF), 0);
        wait_sig("x_exec", 1'b1, 1'b1);
        wait_sig("x_exdrop", 1'b0, 1'b1);
        @(negedge CLK40);
        check("x_wait", {bus.DEV_SEL, BUSY}, 2'b11);
        RST = 1'b1;
        #1;
        check("x_rst", 32'(flags()), 32'b000_0000_0010);
        @(negedge CLK40);
        RST = 1'b0;
        wait_sig("x_rdy", 1'b1, 1'b0);
        repeat (4) @(negedge CLK40);
        wq.delete();
        push(8'h77);
        go(4'd1, 1'b0, 8'h31);
        wait_done(300);
        check("x_done", {NACK_ERR, TO_ERR, BUSY}, 0);
        check("x_wr", 32'(wq[0]), 12'h077);

        // write pointer wrap
        repeat (3) @(negedge CLK40);
        wq.delete();
        for (int i = 0; i < 17; i++) push(8'(i));
        @(negedge CLK40);
        check("p_n", wq.size(), 17);
        check("p_15", 32'(wq[15]), 12'hF0F);
        check("p_16", 32'(wq[16]), 12'h010);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
